// File: rtl/alu_seq.sv
// alu_seq: handshaked unsigned ALU with a valid/ready interface on both sides.
// Logic, add/sub and compare ops finish in one cycle. When ALU_MULDIV_EN is
// defined, MUL/DIV/REM run iteratively over WIDTH cycles: shift-add multiply
// and restoring divide. Without the macro, those opcodes give a zero result.
module alu_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       ALU_ctr,
  input  logic [WIDTH-1:0] data1,
  input  logic [WIDTH-1:0] data2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] ALU_output,
  output logic [WIDTH-1:0] result_hi,
  output logic             Zero,
  output logic             div_zero
);

  localparam logic [3:0] OP_AND = 4'd0;
  localparam logic [3:0] OP_OR  = 4'd1;
  localparam logic [3:0] OP_ADD = 4'd2;
  localparam logic [3:0] OP_SEQ = 4'd3;
  localparam logic [3:0] OP_SLE = 4'd4;
  localparam logic [3:0] OP_SGE = 4'd5;
  localparam logic [3:0] OP_SUB = 4'd6;
  localparam logic [3:0] OP_SLT = 4'd7;
  localparam logic [3:0] OP_NOR = 4'd12;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
`ifdef ALU_MULDIV_EN
    BUSY = 2'd1,
`endif
    DONE = 2'd2
  } state_t;

  state_t           state_r;
  logic             in_ready_r;
  logic             out_valid_r;
  logic [WIDTH-1:0] res_lo_r;
  logic [WIDTH-1:0] res_hi_r;
  logic             zero_r;
  logic             div_zero_r;

  logic [WIDTH-1:0] single_res_s;
  logic [WIDTH-1:0] quick_lo_s;
  logic [WIDTH-1:0] quick_hi_s;
  logic             quick_dz_s;

`ifdef ALU_MULDIV_EN
  localparam logic [3:0] OP_MUL = 4'd8;
  localparam logic [3:0] OP_DIV = 4'd9;
  localparam logic [3:0] OP_REM = 4'd10;
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH - 1);

  logic [CNT_W-1:0] cnt_r;
  logic [3:0]       op_r;
  logic [WIDTH-1:0] opnd_r;     // multiplicand or divisor
  logic [WIDTH-1:0] work_hi_r;  // product high half or partial remainder
  logic [WIDTH-1:0] work_lo_r;  // multiplier bits or dividend/quotient bits

  logic             muldiv_s;
  logic             dz_s;
  logic [WIDTH:0]   mul_sum_s;
  logic [WIDTH:0]   div_shift_s;
  logic [WIDTH:0]   div_diff_s;
  logic [WIDTH-1:0] next_hi_s;
  logic [WIDTH-1:0] next_lo_s;
  logic [WIDTH-1:0] fin_lo_s;

  // Classify the presented opcode: iterative op, and divide by zero shortcut.
  always_comb begin
    muldiv_s = (ALU_ctr == OP_MUL) || (ALU_ctr == OP_DIV) || (ALU_ctr == OP_REM);
    dz_s     = ((ALU_ctr == OP_DIV) || (ALU_ctr == OP_REM)) && (data2 == {WIDTH{1'b0}});
  end

  // One iteration step: shift-add for MUL, restoring subtract for DIV/REM.
  always_comb begin
    mul_sum_s   = {1'b0, work_hi_r} + (work_lo_r[0] ? {1'b0, opnd_r} : {(WIDTH+1){1'b0}});
    div_shift_s = {work_hi_r, work_lo_r[WIDTH-1]};
    div_diff_s  = div_shift_s - {1'b0, opnd_r};
    next_hi_s   = work_hi_r;
    next_lo_s   = work_lo_r;
    if (op_r == OP_MUL) begin
      next_hi_s = mul_sum_s[WIDTH:1];
      next_lo_s = {mul_sum_s[0], work_lo_r[WIDTH-1:1]};
    end else if (!div_diff_s[WIDTH]) begin
      next_hi_s = div_diff_s[WIDTH-1:0];
      next_lo_s = {work_lo_r[WIDTH-2:0], 1'b1};
    end else begin
      next_hi_s = div_shift_s[WIDTH-1:0];
      next_lo_s = {work_lo_r[WIDTH-2:0], 1'b0};
    end
    if (op_r == OP_REM) begin
      fin_lo_s = next_hi_s;
    end else begin
      fin_lo_s = next_lo_s;
    end
  end
`endif

  // Single-cycle result straight from the presented operands.
  always_comb begin
    single_res_s = {WIDTH{1'b0}};
    case (ALU_ctr)
      OP_AND:  single_res_s = data1 & data2;
      OP_OR:   single_res_s = data1 | data2;
      OP_ADD:  single_res_s = data1 + data2;
      OP_SEQ:  single_res_s = {{(WIDTH-1){1'b0}}, (data1 == data2)};
      OP_SLE:  single_res_s = {{(WIDTH-1){1'b0}}, (data1 <= data2)};
      OP_SGE:  single_res_s = {{(WIDTH-1){1'b0}}, (data1 >= data2)};
      OP_SUB:  single_res_s = data1 - data2;
      OP_SLT:  single_res_s = {{(WIDTH-1){1'b0}}, (data1 < data2)};
      OP_NOR:  single_res_s = ~(data1 | data2);
      default: single_res_s = {WIDTH{1'b0}};
    endcase
  end

  // Result captured when an op finishes at accept time (single-cycle or div by zero).
  always_comb begin
    quick_lo_s = single_res_s;
    quick_hi_s = {WIDTH{1'b0}};
    quick_dz_s = 1'b0;
`ifdef ALU_MULDIV_EN
    if (dz_s) begin
      if (ALU_ctr == OP_DIV) begin
        quick_lo_s = {WIDTH{1'b1}};
      end else begin
        quick_lo_s = data1;
      end
      quick_hi_s = data1;
      quick_dz_s = 1'b1;
    end else begin
      quick_lo_s = single_res_s;
      quick_hi_s = {WIDTH{1'b0}};
      quick_dz_s = 1'b0;
    end
`endif
  end

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      res_lo_r    <= {WIDTH{1'b0}};
      res_hi_r    <= {WIDTH{1'b0}};
      zero_r      <= 1'b1;
      div_zero_r  <= 1'b0;
`ifdef ALU_MULDIV_EN
      cnt_r       <= {CNT_W{1'b0}};
      op_r        <= OP_AND;
      opnd_r      <= {WIDTH{1'b0}};
      work_hi_r   <= {WIDTH{1'b0}};
      work_lo_r   <= {WIDTH{1'b0}};
`endif
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
`ifdef ALU_MULDIV_EN
            if (muldiv_s && !dz_s) begin
              state_r    <= BUSY;
              in_ready_r <= 1'b0;
              op_r       <= ALU_ctr;
              cnt_r      <= CNT_MAX;
              work_hi_r  <= {WIDTH{1'b0}};
              if (ALU_ctr == OP_MUL) begin
                opnd_r    <= data1;
                work_lo_r <= data2;
              end else begin
                opnd_r    <= data2;
                work_lo_r <= data1;
              end
            end else begin
`else
            begin
`endif
              state_r     <= DONE;
              in_ready_r  <= 1'b0;
              out_valid_r <= 1'b1;
              res_lo_r    <= quick_lo_s;
              res_hi_r    <= quick_hi_s;
              zero_r      <= (quick_lo_s == {WIDTH{1'b0}});
              div_zero_r  <= quick_dz_s;
            end
          end
        end
`ifdef ALU_MULDIV_EN
        BUSY: begin
          work_hi_r <= next_hi_s;
          work_lo_r <= next_lo_s;
          if (cnt_r == {CNT_W{1'b0}}) begin
            state_r     <= DONE;
            out_valid_r <= 1'b1;
            res_lo_r    <= fin_lo_s;
            res_hi_r    <= next_hi_s;
            zero_r      <= (fin_lo_s == {WIDTH{1'b0}});
            div_zero_r  <= 1'b0;
          end else begin
            cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
`endif
        DONE: begin
          // Result is released; the next accept waits for the following cycle.
          if (out_ready) begin
            state_r     <= IDLE;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
          end
        end
        default: begin
          state_r     <= IDLE;
          in_ready_r  <= 1'b1;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready   = in_ready_r;
  assign out_valid  = out_valid_r;
  assign ALU_output = res_lo_r;
  assign result_hi  = res_hi_r;
  assign Zero       = zero_r;
  assign div_zero   = div_zero_r;

endmodule
